// File: rtl/rst_pkg.sv
// rtl/rst_pkg.sv - shared FSM encoding and cause bit indices for rst_req_gen
package rst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ASSERT = 2'b01,
    ST_HOLD   = 2'b10
  } rst_state_t;

  localparam int unsigned CAUSE_BTN = 0;
  localparam int unsigned CAUSE_SW  = 1;
  localparam int unsigned CAUSE_WDG = 2;
  localparam int unsigned CAUSE_W   = 3;

endpackage

// File: rtl/rst_debounce.sv
// rtl/rst_debounce.sv - 2-flop synchronizer and debounce counter for an active-low button
module rst_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_i,
  input  logic din_n_i,
  output logic press_o,
  output logic level_o
);

  localparam int CNT_W = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(int'(DEBOUNCE_CYCLES) - 1);

  generate
    if (DEBOUNCE_CYCLES < 16'd1) begin : g_bad_debounce
      $error("rst_debounce: DEBOUNCE_CYCLES must be at least 1");
    end
  endgenerate

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt_q;

  // Any cycle where the synchronized input agrees with the accepted level restarts the count
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level_o <= 1'b1;
      press_o <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= din_n_i;
      sync_q2 <= sync_q1;
      press_o <= 1'b0;
      if (sync_q2 == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_o <= sync_q2;
        press_o <= ~sync_q2;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rst_req_gen.sv
// rtl/rst_req_gen.sv - merges button, software and watchdog requests into a minimum-width reset pulse
module rst_req_gen
  import rst_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  PULSE_CYCLES    = 8'd16
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 btn_n_i,
  input  logic                 sw_rst_req_i,
  input  logic                 wdg_rst_req_i,
  input  logic                 cause_clr_i,
  output logic                 rst_req_o,
  output logic [CAUSE_W-1:0]   rst_cause_o
);

  localparam int PCNT_W = $clog2(int'(PULSE_CYCLES) + 1);
  localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(int'(PULSE_CYCLES) - 1);

  generate
    if (PULSE_CYCLES < 8'd1) begin : g_bad_pulse
      $error("rst_req_gen: PULSE_CYCLES must be at least 1");
    end
  endgenerate

  logic               btn_press;
  logic               btn_level;
  logic               wdg_q;
  logic               trigger;
  logic               hold_needed;
  logic [CAUSE_W-1:0] cause_set;
  rst_state_t         state_q;
  logic [PCNT_W-1:0]  pcnt_q;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_i   (rst_i),
    .din_n_i (btn_n_i),
    .press_o (btn_press),
    .level_o (btn_level)
  );

  // A held watchdog level keeps the request up via HOLD; only its rising edge restarts the pulse
  assign trigger     = btn_press | sw_rst_req_i | (wdg_rst_req_i & ~wdg_q);
  assign hold_needed = wdg_rst_req_i | ~btn_level;

  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_BTN] = btn_press;
    cause_set[CAUSE_SW]  = sw_rst_req_i;
    cause_set[CAUSE_WDG] = wdg_rst_req_i;
  end

  // rst_req_o tracks the next state so it rises one cycle after a trigger and falls as IDLE is entered
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      rst_req_o   <= 1'b0;
      wdg_q       <= 1'b0;
      rst_cause_o <= '0;
    end else begin
      wdg_q       <= wdg_rst_req_i;
      rst_cause_o <= (cause_clr_i ? '0 : rst_cause_o) | cause_set;
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q   <= ST_ASSERT;
            pcnt_q    <= PCNT_LOAD;
            rst_req_o <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (trigger) begin
            pcnt_q <= PCNT_LOAD;
          end else if (pcnt_q != '0) begin
            pcnt_q <= pcnt_q - PCNT_W'(1);
          end else if (hold_needed) begin
            state_q <= ST_HOLD;
          end else begin
            state_q   <= ST_IDLE;
            rst_req_o <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (trigger) begin
            state_q <= ST_ASSERT;
            pcnt_q  <= PCNT_LOAD;
          end else if (!hold_needed) begin
            state_q   <= ST_IDLE;
            rst_req_o <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rst_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rst_req_gen.md
RST_REQ_GEN -- requirements
Module: rst_req_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, which is the number of cycles the button must be stable before it is accepted.
REQ-002 SHALL have parameter PULSE_CYCLES, default 8'd16, which is the minimum number of cycles rst_req_o stays high.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high power-on reset.
REQ-005 SHALL have port btn_n_i, input, 1 bit: raw asynchronous reset button, active-low (pressed = 0).
REQ-006 SHALL have port sw_rst_req_i, input, 1 bit: synchronous single-cycle software reset request.
REQ-007 SHALL have port wdg_rst_req_i, input, 1 bit: synchronous watchdog reset request, level.
REQ-008 SHALL have port cause_clr_i, input, 1 bit: synchronous single-cycle clear of rst_cause_o.
REQ-009 SHALL have port rst_req_o, output, 1 bit: registered, active-high reset request to the downstream reset controller.
REQ-010 SHALL have port rst_cause_o, output, 3 bits: sticky cause; bit0 = button, bit1 = software, bit2 = watchdog.

Function
REQ-011 SHALL pass btn_n_i through a 2-flop synchronizer before any other use.
REQ-012 SHALL update the debounced button state only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce reloads the counter.
REQ-013 SHALL generate a one-cycle button event when the debounced state goes from released (1) to pressed (0); release generates no event.
REQ-014 SHALL define trigger = button event OR sw_rst_req_i OR wdg_rst_req_i.
REQ-015 SHALL implement the FSM IDLE -> ASSERT -> HOLD -> IDLE.
REQ-016 SHALL, in IDLE, on trigger, move to ASSERT and load the pulse counter with PULSE_CYCLES-1; rst_req_o goes high the next cycle (1-cycle latency).
REQ-017 SHALL hold rst_req_o = 1 throughout ASSERT and HOLD, and hold rst_req_o = 0 in IDLE.
REQ-018 SHALL, in ASSERT, decrement the pulse counter each cycle and reload it with PULSE_CYCLES-1 on any trigger, so the pulse is extended.
REQ-019 SHALL, in ASSERT, move to HOLD when the counter is 0 and no trigger is present.
REQ-020 SHALL, in HOLD, return to IDLE only when wdg_rst_req_i = 0 and the debounced button is released; a trigger in HOLD re-enters ASSERT with a reload.
REQ-021 SHALL guarantee the total rst_req_o high time is >= PULSE_CYCLES.
REQ-022 SHALL, on each trigger source in any state, OR its bit into rst_cause_o.
REQ-023 SHALL, on cause_clr_i, zero rst_cause_o; a set in the same cycle wins for that bit.
REQ-024 SHALL treat PULSE_CYCLES < 1 as illegal and flag it with an elaboration-time check.

Reset
REQ-025 SHALL, on rst_i, asynchronously force: rst_req_o = 0, FSM = IDLE, counters = 0, rst_cause_o = 3'b000, synchronizer flops = 1, debounced state = released.
REQ-026 SHALL NOT be reset by rst_req_o; only rst_i resets this block, so the cause survives the core reset.
REQ-027 SHALL, if rst_i asserts mid-pulse, drop rst_req_o immediately, and SHALL NOT generate a new request after release unless a new trigger occurs.

Structure
REQ-028 SHALL take the FSM state encoding (2 bits) and the cause bit indices from a shared package rst_pkg.
REQ-029 SHALL place the synchronizer and debounce counter in one sub-module, rst_debounce (ports: clk, rst_i, din_n_i, press_o, level_o).
REQ-030 SHALL size counter widths with $clog2 of the parameters.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=8)
REQ-031 SHALL cover: sw_rst_req_i pulse at cycle 10 -> rst_req_o high cycles 11..18, low at 19, rst_cause_o = 3'b010.
REQ-032 SHALL cover: btn_n_i low with 3-cycle bounces, then stable low -> exactly one pulse, starting 2+4+1 cycles after the stable low; cause bit0 set; rst_req_o stays high while the button is held.
REQ-033 SHALL cover: wdg_rst_req_i held for 20 cycles -> rst_req_o high for 20+ cycles, falling 1 cycle after wdg drops (after at least 8 cycles); cause = 3'b100.
REQ-034 SHALL cover: sw request at cycle 10 and again at cycle 15 -> rst_req_o high cycles 11..23; cause = 3'b010.
REQ-035 SHALL cover: cause_clr_i and sw_rst_req_i in the same cycle with cause = 3'b101 -> cause becomes 3'b010.
REQ-036 SHALL cover: rst_i asserted at pulse cycle 3 -> rst_req_o = 0 asynchronously and cause = 0; no pulse after release.
